// File: rtl/ram_ip_pkg.sv
// Shared defaults and word/address types for the ram_ip single-port RAM.
package ram_ip_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 256;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

endpackage

// File: rtl/ram_ip_array.sv
// Storage array: async clear of every word, rising-edge write, combinational word read.
module ram_ip_array
  import ram_ip_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              write_en,
  output logic [DATA_W-1:0] rd_word
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Word storage: reset clears all words; X/Z on write_en never writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (write_en == 1'b1) begin
      mem_r[addr] <= wr_data;
    end else begin
      mem_r[addr] <= mem_r[addr];
    end
  end

  assign rd_word = mem_r[addr];

endmodule

// File: rtl/ram_ip_core.sv
// Single-port RAM top; RAM_IP_RDREG_EN selects a 1-cycle registered read port,
// otherwise rd_data is a zero-latency combinational read of the addressed word.
module ram_ip_core
  import ram_ip_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              write_en,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_word_s;

  ram_ip_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .wr_data  (wr_data),
    .write_en (write_en),
    .rd_word  (mem_word_s)
  );

`ifdef RAM_IP_RDREG_EN
  logic [DATA_W-1:0] rd_data_r;

  // Read register samples the pre-edge word, giving read-before-write on a same-address write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else begin
      rd_data_r <= mem_word_s;
    end
  end

  assign rd_data = rd_data_r;
`else
  assign rd_data = mem_word_s;
`endif

endmodule

// File: tb/tb_ram_ip_core.sv
// Directed bench for ram_ip_core; read checks wait one edge when RAM_IP_RDREG_EN is defined.
module tb_ram_ip_core;
  import ram_ip_pkg::*;

  logic  clk;
  logic  rst_n;
  addr_t addr;
  data_t wr_data;
  logic  write_en;
  data_t rd_data;

  int checks;
  int failures;

  ram_ip_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .wr_data  (wr_data),
    .write_en (write_en),
    .rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input data_t got, input data_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic write_word(input addr_t a, input data_t d);
    @(negedge clk);
    addr     = a;
    wr_data  = d;
    write_en = 1'b1;
    @(posedge clk);
    #1;
    write_en = 1'b0;
  endtask

  task automatic read_check(input string tag, input addr_t a, input data_t exp);
    addr = a;
`ifdef RAM_IP_RDREG_EN
    @(posedge clk);
`endif
    #1;
    check_val(tag, rd_data, exp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    addr     = 8'd10;
    wr_data  = 8'h00;
    write_en = 1'b0;

    #12;
    check_val("reset_rd", rd_data, 8'h00);

    // write attempt while held in reset must be ignored
    addr     = 8'd10;
    wr_data  = 8'h77;
    write_en = 1'b1;
    @(posedge clk);
    #1;
    check_val("reset_wr_ignored", rd_data, 8'h00);

    // release with a write pending: first edge after release must write
    @(negedge clk);
    wr_data  = 8'h0A;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    write_en = 1'b0;
`ifndef RAM_IP_RDREG_EN
    check_val("first_wr_visible", rd_data, 8'h0A);
`endif

    write_word(8'd11, 8'h0B);
    write_word(8'd31, 8'h0C);
    write_word(8'd32, 8'h0D);

    read_check("burst_rd10", 8'd10, 8'h0A);
    read_check("burst_rd11", 8'd11, 8'h0B);
    read_check("burst_rd31", 8'd31, 8'h0C);
    read_check("burst_rd32", 8'd32, 8'h0D);
    read_check("burst_rd10b", 8'd10, 8'h0A);

    // write disabled: data on the bus must not land
    @(negedge clk);
    addr     = 8'd10;
    wr_data  = 8'hFF;
    write_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    read_check("wr_disabled", 8'd10, 8'h0A);

    write_word(8'd0, 8'h5A);
    write_word(8'd255, 8'hA5);
    read_check("bound_lo", 8'd0, 8'h5A);
    read_check("bound_hi", 8'd255, 8'hA5);
    read_check("nbr_1", 8'd1, 8'h00);
    read_check("nbr_254", 8'd254, 8'h00);

    // reset mid-write between edges; reset wins over the pending write
    @(posedge clk);
    #2;
    addr     = 8'd11;
    wr_data  = 8'h33;
    write_en = 1'b1;
    rst_n    = 1'b0;
    #1;
    check_val("midreset_rd", rd_data, 8'h00);
    @(posedge clk);
    #1;
    check_val("midreset_hold", rd_data, 8'h00);
    @(negedge clk);
    write_en = 1'b0;
    rst_n    = 1'b1;

    read_check("post_rst10", 8'd10, 8'h00);
    read_check("post_rst11", 8'd11, 8'h00);
    read_check("post_rst31", 8'd31, 8'h00);
    read_check("post_rst32", 8'd32, 8'h00);
    read_check("post_rst255", 8'd255, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
